// File: rtl/ajc_8bit_sl_seq_unit_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit.
// Holds the default widths, the function-select codes, the FSM state
// encoding and the packed {C,N,V,Z} flag payload.
package ajc_8bit_sl_seq_unit_pkg;

    localparam int unsigned SL_WIDTH   = 8;
    localparam int unsigned SL_K_WIDTH = 2;

    // Func_Sel codes
    typedef enum logic [1:0] {
        FS_SHRL  = 2'b00,
        FS_SHLA  = 2'b01,
        FS_RLC   = 2'b10,
        FS_PASSY = 2'b11
    } func_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Flag payload, packs to {C,N,V,Z}
    typedef struct packed {
        logic c;
        logic n;
        logic v;
        logic z;
    } cnvz_t;

endpackage

// File: rtl/ajc_nbit_shift_step.sv
// Combinational single-bit step of the shift/rotate unit.
// Ports:
//   r, c         current work value and carry
//   func         operation select (pass-Y holds the value)
//   r_next       value after one step
//   c_next       carry after one step
//   sign_change  SHLA only: the step flipped the sign bit
module ajc_nbit_shift_step
    import ajc_8bit_sl_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH = SL_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic             c,
    input  func_e            func,
    output logic [WIDTH-1:0] r_next,
    output logic             c_next,
    output logic             sign_change
);

    // One-bit step per function
    always_comb begin
        r_next      = r;
        c_next      = c;
        sign_change = 1'b0;
        case (func)
            FS_SHRL: begin
                r_next = {1'b0, r[WIDTH-1:1]};
                c_next = r[0];
            end
            FS_SHLA: begin
                r_next      = {r[WIDTH-2:0], 1'b0};
                c_next      = r[WIDTH-1];
                // new MSB is old r[W-2]
                sign_change = r[WIDTH-1] ^ r[WIDTH-2];
            end
            FS_RLC: begin
                r_next = {r[WIDTH-2:0], c};
                c_next = r[WIDTH-1];
            end
            default: begin
                r_next = r;
                c_next = c;
            end
        endcase
    end

endmodule

// File: rtl/ajc_8bit_sl_seq_unit.sv
// Multi-cycle SHRL/SHLA/RLC/pass-Y unit with Start/Busy/Done handshake.
// One bit is shifted per clock; the control unit stalls on Busy and
// picks up SL_Result/SL_CNVZ while Done is high.
// Ports:
//   Clock, Resetn        clock (rising edge), async active-low reset
//   Start                request, sampled in IDLE or DONE only
//   Func_Sel             00 SHRL, 01 SHLA, 10 RLC, 11 pass Operand_Y
//   Operand_X/Operand_Y  value to shift / pass-through value
//   Const_K              shift count
//   Cin                  carry in for RLC
//   Busy                 high while shifting
//   Done                 one-cycle pulse, result/flags valid
//   SL_Result, SL_CNVZ   registered result and {C,N,V,Z}, held until next op
module ajc_8bit_sl_seq_unit
    import ajc_8bit_sl_seq_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = SL_WIDTH,
    parameter int unsigned K_WIDTH = SL_K_WIDTH
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Start,
    input  logic [1:0]         Func_Sel,
    input  logic [WIDTH-1:0]   Operand_X,
    input  logic [WIDTH-1:0]   Operand_Y,
    input  logic [K_WIDTH-1:0] Const_K,
    input  logic               Cin,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   SL_Result,
    output logic [3:0]         SL_CNVZ
);

    state_e             state_q,  state_nxt;
    func_e              func_q,   func_nxt;
    logic [WIDTH-1:0]   work_q,   work_nxt;
    logic               carry_q,  carry_nxt;
    logic               sticky_q, sticky_nxt;
    logic [K_WIDTH-1:0] count_q,  count_nxt;
    logic               busy_q,   busy_nxt;
    logic               done_q,   done_nxt;
    logic [WIDTH-1:0]   result_q, result_nxt;
    cnvz_t              cnvz_q,   cnvz_nxt;

    logic [WIDTH-1:0]   step_r;
    logic               step_c;
    logic               step_sc;
    func_e              func_in;

    assign func_in = func_e'(Func_Sel);

    // Flags derived from a final value
    function automatic cnvz_t flags_of(input logic [WIDTH-1:0] value,
                                       input logic c, input logic ovf);
        cnvz_t f;
        f.c = c;
        f.n = value[WIDTH-1];
        f.v = ovf;
        f.z = ~|value;
        return f;
    endfunction

    ajc_nbit_shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r           (work_q),
        .c           (carry_q),
        .func        (func_q),
        .r_next      (step_r),
        .c_next      (step_c),
        .sign_change (step_sc)
    );

    // State and datapath registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            func_q   <= FS_SHRL;
            work_q   <= '0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cnvz_q   <= '0;
        end else begin
            state_q  <= state_nxt;
            func_q   <= func_nxt;
            work_q   <= work_nxt;
            carry_q  <= carry_nxt;
            sticky_q <= sticky_nxt;
            count_q  <= count_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            result_q <= result_nxt;
            cnvz_q   <= cnvz_nxt;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_nxt  = state_q;
        func_nxt   = func_q;
        work_nxt   = work_q;
        carry_nxt  = carry_q;
        sticky_nxt = sticky_q;
        count_nxt  = count_q;
        result_nxt = result_q;
        cnvz_nxt   = cnvz_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_nxt = ST_IDLE;
                if (Start) begin
                    func_nxt = func_in;
                    if (func_in == FS_PASSY) begin
                        result_nxt = Operand_Y;
                        cnvz_nxt   = flags_of(Operand_Y, 1'b0, 1'b0);
                        state_nxt  = ST_DONE;
                    end else if (Const_K == '0) begin
                        // zero count: result is X, carry is its initial value
                        result_nxt = Operand_X;
                        cnvz_nxt   = flags_of(Operand_X,
                                              (func_in == FS_RLC) ? Cin : 1'b0,
                                              1'b0);
                        state_nxt  = ST_DONE;
                    end else begin
                        work_nxt   = Operand_X;
                        carry_nxt  = (func_in == FS_RLC) ? Cin : 1'b0;
                        sticky_nxt = 1'b0;
                        count_nxt  = Const_K;
                        state_nxt  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_nxt   = step_r;
                carry_nxt  = step_c;
                sticky_nxt = sticky_q | step_sc;
                count_nxt  = count_q - K_WIDTH'(1);
                if (count_q == K_WIDTH'(1)) begin
                    // last step lands directly in the result registers
                    result_nxt = step_r;
                    cnvz_nxt   = flags_of(step_r, step_c, sticky_q | step_sc);
                    state_nxt  = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt == ST_SHIFT);
        done_nxt = (state_nxt == ST_DONE);
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign SL_Result = result_q;
    assign SL_CNVZ   = cnvz_q;

endmodule
